flow_stage_skid: RTL and testbench

Parametrised pipeline-stage register for the five-stage datapath. It supersedes the fixed per-stage flow registers with one configurable block, instantiated once per stage boundary. Each instance carries a DATA_W-bit payload and a TNEW_W-bit hazard countdown between stages, using a valid/ready handshake backed by a 2-entry skid buffer. The block also provides a synchronous flush, saturating tNew decrement on capture, and a stall-cycle counter for the hazard unit.

---
 rtl/flow_pkg.sv | 21 ++
 rtl/flow_entry.sv | 38 +++
 rtl/flow_stage_skid.sv | 144 ++++++++++++++
 tb/tb_flow_stage_skid.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared definitions for the stage-boundary flow register: state encoding
// and the saturating tNew decrement that the hazard unit also uses.
package flow_pkg;

  // State value doubles as the number of held items.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } flow_state_e;

  // Widest tNew field the shared decrement handles; narrower fields are
  // zero-extended in and truncated back out by the caller.
  localparam int TNEW_MAX_W = 8;

  // tNew counts down once per stage crossing and never wraps below zero.
  function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] value);
    return (value == '0) ? '0 : value - 1'b1;
  endfunction

endpackage

// File: rtl/flow_entry.sv
// One storage slot of the flow register: valid flag, payload and tNew.
// Clear wins over load so a flushed or vacated slot always reads as zero.
module flow_entry
  import flow_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TNEW_W = 3
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              load,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TNEW_W-1:0] tnew_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TNEW_W-1:0] tnew
);

  // Slot register: zero on reset or clear, capture on load, else hold.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid <= 1'b0;
      data  <= '0;
      tnew  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      tnew  <= '0;
    end else if (load) begin
      valid <= valid_in;
      data  <= data_in;
      tnew  <= tnew_in;
    end
  end

endmodule

// File: rtl/flow_stage_skid.sv
// Stage-boundary flow register with a 2-entry skid buffer. The main entry
// drives the outputs; the skid entry absorbs one item when downstream
// stalls so inReady can be a pure function of state.
module flow_stage_skid
  import flow_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TNEW_W = 3,   // must not exceed TNEW_MAX_W
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  input  logic [TNEW_W-1:0] inTNew,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [TNEW_W-1:0] outTNew,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stallCount
);

  flow_state_e state;

  logic accept, deliver;
  logic [TNEW_W-1:0] cap_tnew;

  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic              main_valid_in;
  logic [DATA_W-1:0] main_data_in;
  logic [TNEW_W-1:0] main_tnew_in;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [TNEW_W-1:0] skid_tnew;

  // Ready comes straight from the state register, never from outReady.
  assign inReady   = (state != ST_FULL);
  assign occupancy = state;

  assign accept  = inValid & inReady;
  assign deliver = outValid & outReady;

  // Decrement happens once, at capture; items sitting in a slot keep their tNew.
  assign cap_tnew = TNEW_W'(tnew_dec(TNEW_MAX_W'(inTNew)));

  // Main refills from skid when draining FULL, otherwise from upstream.
  assign main_valid_in = main_from_skid ? skid_valid : 1'b1;
  assign main_data_in  = main_from_skid ? skid_data  : inData;
  assign main_tnew_in  = main_from_skid ? skid_tnew  : cap_tnew;

  // Slot load/clear selection; flush overrides everything and drops any
  // same-cycle accept.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          if (accept && deliver) main_load  = 1'b1;
          else if (accept)       skid_load  = 1'b1;
          else if (deliver)      main_clear = 1'b1;
        end
        ST_FULL: begin
          if (deliver) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state machine.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_ONE;
        ST_ONE: begin
          if (accept && !deliver)      state <= ST_FULL;
          else if (!accept && deliver) state <= ST_EMPTY;
        end
        ST_FULL:  if (deliver) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Saturating count of downstream-stall cycles; flush leaves it alone.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      stallCount <= '0;
    else if (outValid && !outReady && (stallCount != {CNT_W{1'b1}}))
      stallCount <= stallCount + 1'b1;
  end

  flow_entry #(.DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_main (
    .clk      (clk),
    .resetN   (resetN),
    .load     (main_load),
    .clear    (main_clear),
    .valid_in (main_valid_in),
    .data_in  (main_data_in),
    .tnew_in  (main_tnew_in),
    .valid    (outValid),
    .data     (outData),
    .tnew     (outTNew)
  );

  flow_entry #(.DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_skid (
    .clk      (clk),
    .resetN   (resetN),
    .load     (skid_load),
    .clear    (skid_clear),
    .valid_in (1'b1),
    .data_in  (inData),
    .tnew_in  (cap_tnew),
    .valid    (skid_valid),
    .data     (skid_data),
    .tnew     (skid_tnew)
  );

endmodule

// File: tb/tb_flow_stage_skid.sv
// Directed bench for flow_stage_skid. A second instance with a 2-bit stall
// counter shares the stimulus and is used for the saturation sequence.
module tb_flow_stage_skid;

  localparam int DATA_W = 32;
  localparam int TNEW_W = 3;

  logic              clk = 1'b0;
  logic              resetN, flush, inValid, outReady;
  logic [DATA_W-1:0] inData;
  logic [TNEW_W-1:0] inTNew;

  logic              inReady, outValid;
  logic [DATA_W-1:0] outData;
  logic [TNEW_W-1:0] outTNew;
  logic [1:0]        occupancy;
  logic [15:0]       stallCount;

  logic              inReady2, outValid2;
  logic [DATA_W-1:0] outData2;
  logic [TNEW_W-1:0] outTNew2;
  logic [1:0]        occupancy2;
  logic [1:0]        stallCount2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flow_stage_skid #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .CNT_W(16)) dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inData(inData), .inTNew(inTNew),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outTNew(outTNew),
    .occupancy(occupancy), .stallCount(stallCount)
  );

  flow_stage_skid #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .CNT_W(2)) dut2 (
    .clk(clk), .resetN(resetN), .flush(flush),
    .inValid(inValid), .inReady(inReady2), .inData(inData), .inTNew(inTNew),
    .outValid(outValid2), .outReady(outReady), .outData(outData2), .outTNew(outTNew2),
    .occupancy(occupancy2), .stallCount(stallCount2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inData = '0; inTNew = '0;

    // Reset state
    #3;
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_inReady",  32'(inReady), 1);
    chk("rst_occ",      32'(occupancy), 0);
    chk("rst_stall",    32'(stallCount), 0);
    chk("rst_outData",  outData, 0);
    #9 resetN = 1'b1;   // t=12, between edges

    // Stream 1..4 with tNew=2 at full throughput
    outReady = 1'b1;
    inValid  = 1'b1;
    inTNew   = 3'd2;
    for (int i = 1; i <= 4; i++) begin
      inData = 32'(i);
      step();
      chk($sformatf("stream_data%0d", i), outData, 32'(i));
      chk($sformatf("stream_tnew%0d", i), 32'(outTNew), 1);
      chk($sformatf("stream_occ%0d", i), 32'(occupancy), 1);
    end
    inValid = 1'b0;
    step();
    chk("stream_drain_valid", 32'(outValid), 0);
    chk("stream_drain_data",  outData, 0);
    chk("stream_stall",       32'(stallCount), 0);

    // Backpressure: A (tNew 0), then B, C while stalled
    outReady = 1'b0;
    inValid  = 1'b1;
    inData = 32'hA; inTNew = 3'd0;
    step();
    chk("bp_A_data", outData, 32'hA);
    chk("bp_A_tnew", 32'(outTNew), 0);
    chk("bp_A_occ",  32'(occupancy), 1);
    inData = 32'hB; inTNew = 3'd5;
    step();
    chk("bp_B_occ",     32'(occupancy), 2);
    chk("bp_B_inReady", 32'(inReady), 0);
    chk("bp_B_head",    outData, 32'hA);
    inData = 32'hC; inTNew = 3'd1;
    step();
    step();
    chk("bp_stall3",  32'(stallCount), 3);
    chk("bp_C_occ",   32'(occupancy), 2);
    chk("bp_C_head",  outData, 32'hA);
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    chk("bp_drain_B_data", outData, 32'hB);
    chk("bp_drain_B_tnew", 32'(outTNew), 4);
    chk("bp_drain_B_occ",  32'(occupancy), 1);
    chk("bp_stall_hold",   32'(stallCount), 3);
    step();
    chk("bp_drain_empty", 32'(outValid), 0);
    chk("bp_drain_occ",   32'(occupancy), 0);

    // Flush while FULL with a simultaneous offer
    outReady = 1'b0;
    inValid  = 1'b1;
    inData = 32'h11; inTNew = 3'd1;
    step();
    inData = 32'h22;
    step();
    chk("fl_pre_occ", 32'(occupancy), 2);
    flush  = 1'b1;
    inData = 32'h33;
    step();
    flush   = 1'b0;
    inValid = 1'b0;
    chk("fl_valid",   32'(outValid), 0);
    chk("fl_data",    outData, 0);
    chk("fl_occ",     32'(occupancy), 0);
    chk("fl_inReady", 32'(inReady), 1);
    chk("fl_stall",   32'(stallCount), 5);
    outReady = 1'b1;
    step();
    chk("fl_no_item", 32'(outValid), 0);

    // Asynchronous reset while FULL
    outReady = 1'b0;
    inValid  = 1'b1;
    inData = 32'h44; inTNew = 3'd3;
    step();
    inData = 32'h55;
    step();
    inValid = 1'b0;
    chk("ar_pre_occ", 32'(occupancy), 2);
    #2 resetN = 1'b0;
    #1;
    chk("ar_valid",   32'(outValid), 0);
    chk("ar_data",    outData, 0);
    chk("ar_tnew",    32'(outTNew), 0);
    chk("ar_occ",     32'(occupancy), 0);
    chk("ar_inReady", 32'(inReady), 1);
    chk("ar_stall",   32'(stallCount), 0);
    #3 resetN = 1'b1;

    // Stall counter saturation on the 2-bit instance
    outReady = 1'b0;
    inValid  = 1'b1;
    inData = 32'h66; inTNew = 3'd0;
    step();
    inValid = 1'b0;
    chk("sat_start", 32'(stallCount2), 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("sat_cnt%0d", i), 32'(stallCount2), (i < 3) ? 32'(i) : 32'd3);
      chk($sformatf("wide_cnt%0d", i), 32'(stallCount), 32'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
